// File: rtl/alu_muldiv_seq.sv
// Iterative radix-2 multiply/divide unit for the RISC-V M-extension ops.
// Works on operand magnitudes and applies sign correction in a final FIX cycle.
module alu_muldiv_seq #(
  parameter int N = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         flush_i,
  input  logic [2:0]   op_i,
  input  logic [N-1:0] A_i,
  input  logic [N-1:0] B_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] sal_o,
  output logic         dz_o
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_N   = CW'(N);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [N-1:0]  ZERO_N  = {N{1'b0}};
  localparam logic [N-1:0]  ONES_N  = {N{1'b1}};
  localparam logic [N-1:0]  MIN_INT = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  function automatic logic [N-1:0] cond_neg_n(input logic [N-1:0] v, input logic en);
    if (en) return ZERO_N - v;
    else    return v;
  endfunction

  function automatic logic [2*N-1:0] cond_neg_2n(input logic [2*N-1:0] v, input logic en);
    if (en) return {(2*N){1'b0}} - v;
    else    return v;
  endfunction

  state_t          state_r, state_next_s;
  logic [CW-1:0]   cnt_r, cnt_next_s;
  logic [2:0]      op_r, op_next_s;
  logic            sa_r, sa_next_s, sb_r, sb_next_s;
  logic            special_r, special_next_s;
  logic            dz_pend_r, dz_pend_next_s;
  logic [N-1:0]    opnd_r, opnd_next_s;
  logic [2*N-1:0]  acc_r, acc_next_s;
  logic [N-1:0]    sal_r, sal_next_s;
  logic            dz_r, dz_next_s;
  logic            done_r, done_next_s;
  logic            busy_r;

  logic            sign_a_s, sign_b_s, div_zero_s, ovf_s;
  logic [N-1:0]    mag_a_s, mag_b_s;
  logic [N:0]      sum_s, rem_sh_s, diff_s;
  logic [2*N-1:0]  mul_step_s, div_step_s, prod_s;
  logic [N-1:0]    quo_s, rem_s, result_s;

  // Operand decode at acceptance: signedness, magnitudes and special divides
  always_comb begin
    sign_a_s = 1'b0;
    sign_b_s = 1'b0;
    case (op_i)
      3'b001, 3'b100, 3'b110: begin
        sign_a_s = A_i[N-1];
        sign_b_s = B_i[N-1];
      end
      3'b010:  sign_a_s = A_i[N-1];
      default: sign_a_s = 1'b0;
    endcase
    mag_a_s    = cond_neg_n(A_i, sign_a_s);
    mag_b_s    = cond_neg_n(B_i, sign_b_s);
    div_zero_s = op_i[2] && (B_i == ZERO_N);
    ovf_s      = op_i[2] && !op_i[0] && (A_i == MIN_INT) && (B_i == ONES_N);
  end

  // One radix-2 iteration for multiply (shift-add) and restoring divide
  always_comb begin
    sum_s      = {1'b0, acc_r[2*N-1:N]} + (acc_r[0] ? {1'b0, opnd_r} : {(N+1){1'b0}});
    mul_step_s = {sum_s, acc_r[N-1:1]};
    rem_sh_s   = {acc_r[2*N-1:N], acc_r[N-1]};
    diff_s     = rem_sh_s - {1'b0, opnd_r};
    if (!diff_s[N]) begin
      div_step_s = {diff_s[N-1:0], acc_r[N-2:0], 1'b1};
    end else begin
      div_step_s = {rem_sh_s[N-1:0], acc_r[N-2:0], 1'b0};
    end
  end

  // Sign correction and result selection used in the FIX cycle
  always_comb begin
    prod_s = cond_neg_2n(acc_r, sa_r ^ sb_r);
    quo_s  = cond_neg_n(acc_r[N-1:0], sa_r ^ sb_r);
    rem_s  = cond_neg_n(acc_r[2*N-1:N], sa_r);
    case (op_r)
      3'b000:                 result_s = prod_s[N-1:0];
      3'b001, 3'b010, 3'b011: result_s = prod_s[2*N-1:N];
      3'b100, 3'b101:         result_s = special_r ? acc_r[N-1:0] : quo_s;
      3'b110, 3'b111:         result_s = special_r ? acc_r[2*N-1:N] : rem_s;
      default:                result_s = ZERO_N;
    endcase
  end

  // Next-state and datapath update; flush aborts without touching the outputs
  always_comb begin
    state_next_s   = state_r;
    cnt_next_s     = cnt_r;
    op_next_s      = op_r;
    sa_next_s      = sa_r;
    sb_next_s      = sb_r;
    special_next_s = special_r;
    dz_pend_next_s = dz_pend_r;
    opnd_next_s    = opnd_r;
    acc_next_s     = acc_r;
    sal_next_s     = sal_r;
    dz_next_s      = dz_r;
    done_next_s    = 1'b0;
    if (flush_i) begin
      state_next_s = ST_IDLE;
      cnt_next_s   = {CW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            op_next_s      = op_i;
            sa_next_s      = sign_a_s;
            sb_next_s      = sign_b_s;
            dz_pend_next_s = div_zero_s;
            special_next_s = div_zero_s || ovf_s;
            if (div_zero_s) begin
              acc_next_s   = {A_i, ONES_N};
              cnt_next_s   = {CW{1'b0}};
              state_next_s = ST_FIX;
            end else if (ovf_s) begin
              acc_next_s   = {ZERO_N, A_i};
              cnt_next_s   = {CW{1'b0}};
              state_next_s = ST_FIX;
            end else if (op_i[2]) begin
              acc_next_s   = {ZERO_N, mag_a_s};
              opnd_next_s  = mag_b_s;
              cnt_next_s   = CNT_N;
              state_next_s = ST_CALC;
            end else begin
              acc_next_s   = {ZERO_N, mag_b_s};
              opnd_next_s  = mag_a_s;
              cnt_next_s   = CNT_N;
              state_next_s = ST_CALC;
            end
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_CALC: begin
          acc_next_s = op_r[2] ? div_step_s : mul_step_s;
          cnt_next_s = cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_next_s = ST_FIX;
          end else begin
            state_next_s = ST_CALC;
          end
        end
        ST_FIX: begin
          sal_next_s   = result_s;
          dz_next_s    = dz_pend_r;
          done_next_s  = 1'b1;
          state_next_s = ST_IDLE;
        end
        default: begin
          state_next_s = ST_IDLE;
          cnt_next_s   = {CW{1'b0}};
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CW{1'b0}};
      op_r      <= 3'b000;
      sa_r      <= 1'b0;
      sb_r      <= 1'b0;
      special_r <= 1'b0;
      dz_pend_r <= 1'b0;
      opnd_r    <= ZERO_N;
      acc_r     <= {(2*N){1'b0}};
      sal_r     <= ZERO_N;
      dz_r      <= 1'b0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      cnt_r     <= cnt_next_s;
      op_r      <= op_next_s;
      sa_r      <= sa_next_s;
      sb_r      <= sb_next_s;
      special_r <= special_next_s;
      dz_pend_r <= dz_pend_next_s;
      opnd_r    <= opnd_next_s;
      acc_r     <= acc_next_s;
      sal_r     <= sal_next_s;
      dz_r      <= dz_next_s;
      done_r    <= done_next_s;
      busy_r    <= (state_next_s != ST_IDLE);
    end
  end

  assign busy_o = busy_r;
  assign done_o = done_r;
  assign sal_o  = sal_r;
  assign dz_o   = dz_r;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Table-driven bench for alu_muldiv_seq plus hand-written flush, busy-start and reset sequences.
module tb_alu_muldiv_seq;

  logic        clk, rst, start, flush, busy, done, dz;
  logic [2:0]  op;
  logic [31:0] a, b, sal;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sal;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  alu_muldiv_seq #(.N(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .flush_i(flush),
    .op_i(op), .A_i(a), .B_i(b),
    .busy_o(busy), .done_o(done), .sal_o(sal), .dz_o(dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                              input logic [31:0] r, input logic d, input int l);
    vec_t v;
    v.op = o; v.a = x; v.b = y; v.sal = r; v.dz = d; v.lat = l;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Called at a negedge: issues one op, optionally pokes start or flush mid-run,
  // returns at the negedge of the done cycle (or after the cycle budget).
  task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                     input int poke_cyc, input int flush_cyc,
                     output logic [31:0] r, output logic d, output int lat, output bit busy_ok);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = ~x; b = ~y; op = ~o;
    lat = 0; busy_ok = 1'b1; r = 32'd0; d = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == poke_cyc + 1) start = 1'b0;
      if (k == flush_cyc + 1) flush = 1'b0;
      if (done) begin
        lat = k; r = sal; d = dz;
        if (busy) busy_ok = 1'b0;
        break;
      end else if (busy != ((flush_cyc == 0) || (k <= flush_cyc))) begin
        busy_ok = 1'b0;
      end
      if (k == poke_cyc) begin
        start = 1'b1; a = 32'd100; b = 32'd3; op = 3'b101;
      end
      if (k == flush_cyc) flush = 1'b1;
    end
  endtask

  logic [31:0] r, prev;
  logic        d;
  int          lat;
  bit          bok;

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    vecs.push_back(mk(3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 34));
    vecs.push_back(mk(3'b000, 32'd3,        32'd4,        32'd12,       1'b0, 34));
    vecs.push_back(mk(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 34));
    vecs.push_back(mk(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 34));
    vecs.push_back(mk(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 34));
    vecs.push_back(mk(3'b011, 32'hFFFFFFFF, 32'd2,        32'd1,        1'b0, 34));
    vecs.push_back(mk(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        1'b0, 34));
    vecs.push_back(mk(3'b100, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        1'b0, 34));
    vecs.push_back(mk(3'b110, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, 34));
    vecs.push_back(mk(3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 34));
    vecs.push_back(mk(3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        1'b0, 34));
    vecs.push_back(mk(3'b101, 32'hFFFFFFFF, 32'h80000000, 32'd1,        1'b0, 34));
    vecs.push_back(mk(3'b111, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 1'b0, 34));
    vecs.push_back(mk(3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b0, 34));
    vecs.push_back(mk(3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, 2));
    vecs.push_back(mk(3'b111, 32'd5,        32'd0,        32'd5,        1'b1, 2));
    vecs.push_back(mk(3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1'b1, 2));
    vecs.push_back(mk(3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, 2));
    vecs.push_back(mk(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 2));
    vecs.push_back(mk(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b0, 2));

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'b000; a = 32'd0; b = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_sal", sal, 32'd0);
    chk("reset_dz", {31'd0, dz}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      run(vecs[i].op, vecs[i].a, vecs[i].b, 0, 0, r, d, lat, bok);
      chk($sformatf("vec%0d_sal", i), r, vecs[i].sal);
      chk($sformatf("vec%0d_dz", i), {31'd0, d}, {31'd0, vecs[i].dz});
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_busy", i), {31'd0, bok}, 32'd1);
      @(negedge clk);
      chk($sformatf("vec%0d_pulse", i), {31'd0, done}, 32'd0);
      chk($sformatf("vec%0d_hold", i), sal, vecs[i].sal);
    end

    // Back-to-back divides: each new start sits in the previous done cycle
    run(3'b100, 32'hFFFFFFF9, 32'd2, 0, 0, r, d, lat, bok);
    chk("b2b_div", r, 32'hFFFFFFFD);
    chk("b2b_div_lat", lat, 34);
    run(3'b110, 32'hFFFFFFF9, 32'd2, 0, 0, r, d, lat, bok);
    chk("b2b_rem", r, 32'hFFFFFFFF);
    chk("b2b_rem_lat", lat, 34);
    run(3'b101, 32'd100, 32'd7, 0, 0, r, d, lat, bok);
    chk("b2b_divu", r, 32'd14);
    chk("b2b_divu_busy", {31'd0, bok}, 32'd1);
    run(3'b111, 32'd100, 32'd7, 0, 0, r, d, lat, bok);
    chk("b2b_remu", r, 32'd2);
    chk("b2b_remu_lat", lat, 34);

    // Flush at cycle 10 of a DIVU: no done, result register untouched
    @(negedge clk);
    prev = sal;
    run(3'b101, 32'd1000, 32'd9, 0, 10, r, d, lat, bok);
    chk("flush_no_done", lat, 0);
    chk("flush_busy", {31'd0, bok}, 32'd1);
    chk("flush_sal_kept", sal, prev);

    // Flush together with start in IDLE: nothing accepted
    op = 3'b101; a = 32'd100; b = 32'd7; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("flush_start_done", {31'd0, done}, 32'd0);

    // start pulsed while busy with different operands is ignored
    run(3'b000, 32'd3, 32'd5, 5, 0, r, d, lat, bok);
    chk("busy_start_sal", r, 32'd15);
    chk("busy_start_lat", lat, 34);
    @(negedge clk);
    chk("busy_start_idle", {31'd0, busy}, 32'd0);

    // Asynchronous reset mid-CALC clears outputs before any clock edge
    run(3'b100, 32'd5, 32'd0, 0, 0, r, d, lat, bok);
    chk("pre_reset_dz", {31'd0, d}, 32'd1);
    @(negedge clk);
    op = 3'b000; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (12) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("areset_busy", {31'd0, busy}, 32'd0);
    chk("areset_done", {31'd0, done}, 32'd0);
    chk("areset_sal", sal, 32'd0);
    chk("areset_dz", {31'd0, dz}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run(3'b000, 32'd3, 32'd4, 0, 0, r, d, lat, bok);
    chk("post_reset_mul", r, 32'd12);
    chk("post_reset_lat", lat, 34);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_seq.md
# alu_muldiv_seq

Iterative N-bit multiply/divide unit, the multi-cycle successor to the single-cycle N-bit ALU. It runs the RISC-V M-extension operations: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU. It sits beside the combinational ALU in the execute stage and stalls the core through a start/busy/done handshake. Arithmetic is radix-2, one bit per cycle, on magnitudes, with sign correction in a final cycle.

## Interface
- N, 32, operand and result width (≥ 4); counter width is clog2(N+1).
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  request; accepted only in IDLE.
- flush_i  in  1  synchronous abort; highest priority after reset.
- op_i  in  3  operation, funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- A_i  in  N  operand 1 (multiplicand / dividend); sampled at acceptance.
- B_i  in  N  operand 2 (multiplier / divisor); sampled at acceptance.
- busy_o  out  1  high while state ≠ IDLE.
- done_o  out  1  one-cycle pulse: sal_o and dz_o valid.
- sal_o  out  N  result register; holds its value until the next done_o.
- dz_o  out  1  divide-by-zero flag; registered with done_o, held like sal_o.

## Operation
- States: IDLE, CALC, FIX.
- IDLE + start_i → latch op, signs and magnitudes.
  - Signed A: op ∈ {MULH, MULHSU, DIV, REM}.
  - Signed B: op ∈ {MULH, DIV, REM}.
  - Default next state is CALC with count = N.
- Special divides skip CALC and go IDLE → FIX:
  - B = 0: quotient = all ones; remainder = A; dz_o = 1.
  - Signed overflow (DIV/REM, A = 100…0, B = all ones): quotient = A; remainder = 0; dz_o = 0.
  - MUL ops never take the special path.
- CALC, multiply: shift-add into a 2N-bit accumulator; N iterations.
- CALC, divide: restoring; shift the remainder left, subtract the divisor magnitude, set the quotient bit when the result is ≥ 0; N iterations.
- CALC → FIX when count reaches 0 after the N-th iteration.
- FIX sign correction:
  - Product negated if sA^sB.
  - Quotient negated if sA^sB.
  - Remainder takes the sign of A.
- FIX result selection:
  - MUL → low N bits.
  - MULH/MULHSU/MULHU → high N bits.
  - DIV/DIVU → quotient.
  - REM/REMU → remainder.
- FIX → IDLE. On that edge sal_o and dz_o are loaded and done_o = 1 for exactly one cycle.
- start_i while busy_o = 1 is ignored. Operand changes after acceptance have no effect.
- flush_i = 1 at an edge in any state:
  - State goes to IDLE and the counter is cleared.
  - sal_o, dz_o and done_o are not updated (done_o = 0).
  - flush_i with start_i in IDLE: the flush wins and nothing is accepted.
- Reset values: state IDLE, busy_o 0, done_o 0, sal_o 0, dz_o 0, counter 0, accumulators 0. Reset mid-operation abandons the job with no done_o.

## Timing
- Acceptance edge = edge 0.
- Normal path: busy_o = 1 in cycles 1..N+1. done_o = 1 in cycle N+2, with busy_o = 0 in that cycle. Latency is N+2 edges (34 for N=32).
- Special-divide path: busy_o = 1 in cycle 1. done_o = 1 in cycle 2.
- Back-to-back: start_i may be high in the done_o cycle. It is accepted, giving throughput of one op per N+2 cycles.
- No combinational path from inputs to outputs.

## Test plan
- MUL A=7, B=0xFFFFFFFD (−3), N=32 → done_o at cycle 34, sal_o=0xFFFFFFEB, dz_o=0; busy_o high in cycles 1–33.
- High-product ops:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Divide and remainder:
  - DIV 0xFFFFFFF9 (−7)/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU → 2.
  - Run back-to-back, with start_i asserted in each done_o cycle.
- Special cases:
  - DIV 5/0 → done_o at cycle 2, sal_o=0xFFFFFFFF, dz_o=1.
  - REMU 5/0 → 5, dz_o=1.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0; dz_o=0.
- Abort and protocol:
  - flush_i at cycle 10 of a DIVU → busy_o=0 from cycle 11, no done_o, sal_o keeps its prior value.
  - start_i pulsed during busy with a changed A_i → ignored; the original result is returned.
- Reset: rst_i asserted asynchronously mid-CALC → busy_o, done_o, sal_o and dz_o go to 0 immediately, without waiting for a clock edge. A fresh MUL 3×4 after release → 12 at cycle 34.
